// File: rtl/fetch_stage_controller.sv
// Instruction-fetch front end: owns the PC and the IF/ID register, raises a fetch fault and
// halts on a misaligned or out-of-window PC until a redirect or reset.
module fetch_stage_controller #(
    parameter int unsigned MEMORY_DEPTH = 64,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_rom_address,
    input  logic [31:0] i_rom_instruction,
    output logic [31:0] o_if_instruction,
    output logic [31:0] o_if_pc_plus4,
    output logic        o_if_valid,
    output logic        o_fault,
    output logic [31:0] o_fault_pc,
    output logic [31:0] o_fetch_count,
    output logic [31:0] o_bubble_count
);

    typedef enum logic [0:0] {StRun, StHalt} stateT;

    stateT       stateQ, stateD;
    logic [31:0] pcQ, pcD;
    logic [31:0] ifInstrQ, ifInstrD;
    logic [31:0] ifPcPlus4Q, ifPcPlus4D;
    logic        ifValidQ, ifValidD;
    logic [31:0] faultPcQ, faultPcD;
    logic [31:0] fetchCountQ, fetchCountD;
    logic [31:0] bubbleCountQ, bubbleCountD;

    logic [31:0] pcPlus4;
    logic [31:0] pcOffset;
    logic        aligned;
    logic        inRange;
    logic        pcLegal;

    logic        takeRedirect;
    logic        loadFetch;
    logic        loadBubble;
    logic        recordFault;

    // A PC below RESET_PC wraps to a huge offset and falls out of range.
    assign pcPlus4  = pcQ + 32'd4;
    assign pcOffset = pcQ - RESET_PC;
    assign aligned  = (pcQ[1:0] == 2'b00);
    assign inRange  = (pcOffset >> 2) < MEMORY_DEPTH;
    assign pcLegal  = aligned && inRange;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StRun;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        if (i_redirect_valid) begin
            stateD = StRun;
        end else begin
            unique case (stateQ)
                StRun:   if (!i_stall && !pcLegal) stateD = StHalt;
                StHalt:  stateD = StHalt;
                default: stateD = StRun;
            endcase
        end
    end

    // Action decode; priority is redirect > halt > stall > fetch.
    always_comb begin
        takeRedirect = 1'b0;
        loadFetch    = 1'b0;
        loadBubble   = 1'b0;
        recordFault  = 1'b0;
        if (i_redirect_valid) begin
            takeRedirect = 1'b1;
            loadBubble   = 1'b1;
        end else if (stateQ == StRun && !i_stall) begin
            if (pcLegal) begin
                loadFetch = 1'b1;
            end else begin
                recordFault = 1'b1;
                loadBubble  = 1'b1;
            end
        end
    end

    // Datapath next values
    always_comb begin
        pcD          = pcQ;
        ifInstrD     = ifInstrQ;
        ifPcPlus4D   = ifPcPlus4Q;
        ifValidD     = ifValidQ;
        faultPcD     = faultPcQ;
        fetchCountD  = fetchCountQ;
        bubbleCountD = bubbleCountQ;

        if (takeRedirect) begin
            pcD = i_redirect_pc;
        end else if (loadFetch) begin
            pcD = pcPlus4;
        end

        if (loadFetch) begin
            ifInstrD    = i_rom_instruction;
            ifPcPlus4D  = pcPlus4;
            ifValidD    = 1'b1;
            fetchCountD = fetchCountQ + 32'd1;
        end else if (loadBubble) begin
            ifInstrD     = 32'd0;
            ifPcPlus4D   = 32'd0;
            ifValidD     = 1'b0;
            bubbleCountD = bubbleCountQ + 32'd1;
        end

        if (recordFault) begin
            faultPcD = pcQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcQ          <= RESET_PC;
            ifInstrQ     <= 32'd0;
            ifPcPlus4Q   <= 32'd0;
            ifValidQ     <= 1'b0;
            faultPcQ     <= 32'd0;
            fetchCountQ  <= 32'd0;
            bubbleCountQ <= 32'd0;
        end else begin
            pcQ          <= pcD;
            ifInstrQ     <= ifInstrD;
            ifPcPlus4Q   <= ifPcPlus4D;
            ifValidQ     <= ifValidD;
            faultPcQ     <= faultPcD;
            fetchCountQ  <= fetchCountD;
            bubbleCountQ <= bubbleCountD;
        end
    end

    // Outputs
    always_comb begin
        o_rom_address    = pcQ;
        o_if_instruction = ifInstrQ;
        o_if_pc_plus4    = ifPcPlus4Q;
        o_if_valid       = ifValidQ;
        o_fault          = (stateQ == StHalt);
        o_fault_pc       = faultPcQ;
        o_fetch_count    = fetchCountQ;
        o_bubble_count   = bubbleCountQ;
    end

endmodule

// File: doc/fetch_stage_controller.md
Name: fetch_stage_controller

Overview:
Instruction-fetch front end of the pipelined MIPS core. It owns the program counter and the IF/ID pipeline register, and drives the combinational ProgramMemory address. It accepts the registered branch/jump/jr redirect from later stages and a stall from decode. It loads bubbles on redirect or fault, and detects fetch faults: misaligned PC or PC outside program memory.

Parameters:
MEMORY_DEPTH, 64, program memory size in 32-bit words; legal fetch window is RESET_PC .. RESET_PC+4*MEMORY_DEPTH-4
RESET_PC, 32'h0000_0000, PC value loaded at reset; must be word aligned

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
i_stall  input  1  hold PC and IF/ID contents (decode hazard)
i_redirect_valid  input  1  redirect PC this cycle (taken branch, jump, jr)
i_redirect_pc  input  32  redirect target
o_rom_address  output  32  current PC to ProgramMemory (combinational from PC register)
i_rom_instruction  input  32  instruction returned combinationally for o_rom_address
o_if_instruction  output  32  IF/ID instruction
o_if_pc_plus4  output  32  IF/ID PC+4
o_if_valid  output  1  IF/ID holds a real instruction (0 = bubble)
o_fault  output  1  fetch fault; the controller is in HALT
o_fault_pc  output  32  PC that caused the last fault
o_fetch_count  output  32  number of valid instructions loaded into IF/ID
o_bubble_count  output  32  number of bubbles loaded into IF/ID

Behaviour:
- Single clock domain. All state updates on the rising edge of clk. Reset is synchronous, active-high.
- Reset values:
  - PC = RESET_PC, state = RUN
  - o_if_instruction = 0 (NOP), o_if_pc_plus4 = 0, o_if_valid = 0
  - o_fault = 0, o_fault_pc = 0
  - o_fetch_count = 0, o_bubble_count = 0
- PC legality, computed combinationally:
  - aligned = (PC[1:0] == 0)
  - in_range = ((PC - RESET_PC) >> 2) < MEMORY_DEPTH, with 32-bit modulo subtraction; a PC below RESET_PC wraps to a large value and is therefore out of range
  - legal = aligned & in_range
- States: RUN and HALT. o_fault = (state == HALT).
- Per-edge priority: reset > redirect > HALT > stall > normal fetch.
- Redirect (i_redirect_valid=1, any state, regardless of i_stall):
  - PC <= i_redirect_pc
  - IF/ID <= bubble (instruction 0, pc_plus4 0, valid 0); o_bubble_count += 1
  - state <= RUN
  - Legality of the new PC is checked on the following cycle as a normal fetch.
- HALT (no redirect): PC holds, IF/ID holds a bubble, counters hold, i_stall is ignored. Only reset or a redirect exits HALT.
- RUN with i_stall=1 (no redirect): PC, IF/ID and counters hold. No fault check is made.
- RUN, no stall, legal PC:
  - IF/ID <= {i_rom_instruction, PC+4, valid=1}
  - PC <= PC+4 (32-bit wrap)
  - o_fetch_count += 1
- RUN, no stall, illegal PC:
  - state <= HALT; o_fault_pc <= PC; PC holds
  - IF/ID <= bubble; o_bubble_count += 1
- Latency: an instruction at PC appears on o_if_* one edge after PC is presented on o_rom_address.
- Both counters wrap modulo 2^32.
- o_fault_pc keeps its value after leaving HALT and is overwritten only by the next fault.
- Redirect and stall in the same cycle: redirect wins, the stall is dropped, and a bubble is loaded.

Test Plan:
- Reset, then 4 free-running cycles with ROM words 0x20080001, 0x20090002, 0x01095020, 0x00000000 at PCs 0..0xC -> o_if_pc_plus4 is 4, 8, 0xC, 0x10 with the matching instructions; o_if_valid=1; o_fetch_count=4.
- At PC=8, assert i_stall for 3 cycles -> PC stays 8, o_if_* unchanged, counters unchanged; after release the next edge loads the instruction at 8 with pc_plus4=0xC.
- At PC=0x10, assert i_redirect_valid=1 with i_redirect_pc=0x4 and i_stall=1 -> next edge: o_if_valid=0, o_if_instruction=0, o_bubble_count=1, o_rom_address=0x4; the following edge fetches 0x4 with pc_plus4=0x8.
- Redirect to 0x102 -> one bubble, then on the next edge o_fault=1, o_fault_pc=0x102; 5 further cycles with i_stall toggling leave PC=0x102 and o_bubble_count=2.
- With MEMORY_DEPTH=64, run sequentially to PC=0xFC -> 0xFC is fetched valid; at PC=0x100 o_fault=1, o_fault_pc=0x100. Redirect to 0x0 -> o_fault=0, o_fault_pc stays 0x100, and fetch resumes from 0x0.
- Assert reset for one cycle mid-HALT with counters nonzero -> next edge: PC=RESET_PC, state RUN, all outputs at their reset values including o_fault_pc=0 and both counters 0.
